muldiv_hilo_unit: RTL
=====================

// Module: muldiv_hilo_unit
// PURPOSE
// - E-stage multiply/divide unit; sole writer of HI/LO. The WB decoder's mfhi/mflo path reads HI/LO.
// - Decodes mult/multu/div/divu/mthi/mtlo from IR_E.
// - Runs multi-cycle operations with a fixed-latency counter.
// - Drives busy/start to the hazard unit, which stalls mf*/md instructions in D.
// PARAMETERS
// - MULT_LAT  5   cycles busy for mult/multu (>=1)
// - DIV_LAT   10  cycles busy for div/divu (>=1)
// PORTS
// - clk     in   1   rising-edge clock
// - rst_n   in   1   asynchronous, active-low reset
// - IR_E    in   32  instruction in E stage (0 = nop)
// - A       in   32  forwarded rs value
// - B       in   32  forwarded rt value
// - start   out  1   comb: IR_E is mult/multu/div/divu and !busy
// - busy    out  1   operation in flight
// - HI      out  32  architectural HI
// - LO      out  32  architectural LO
// BEHAVIOUR
// - Reset (async, rst_n=0): busy=0, counter=0, HI=LO=0, staging regs=0.
//   Asserting reset mid-operation aborts it; no commit happens.
// - Decode:
//   - op=000000 with funct 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
//   - Any other IR_E is a no-op for this block.
// - States: IDLE(busy=0) and RUN(busy=1). Counter cnt is 4..5 bits, sized for the larger LAT.
//   - IDLE + start at edge T: compute result into stage_hi/stage_lo; cnt<=LAT-1 for the op; busy<=1.
//   - RUN, cnt!=0: cnt<=cnt-1.
//   - RUN, cnt==0: HI<=stage_hi, LO<=stage_lo, busy<=0. This is the edge T+LAT.
//   - Net timing: busy is high for exactly LAT cycles; new HI/LO are visible in the cycle after busy falls.
//   - HI/LO keep their old values while busy.
// - mthi/mtlo, only when !busy: HI<=A (mthi) or LO<=A (mtlo) at the next edge, single cycle, busy stays 0.
// - While busy, md ops and mthi/mtlo in IR_E are ignored (start=0).
//   The hazard unit guarantees they are stalled in D; the block does not queue them.
// - Arithmetic:
//   - mult: {HI,LO} = $signed(A) * $signed(B), full 64-bit product.
//   - multu: {HI,LO} = unsigned 64-bit product.
//   - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//   - divu: unsigned quotient and remainder.
//   - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
//   - Divide by zero (div/divu): full DIV_LAT busy period still runs; at commit HI/LO are left unchanged.
// - Back-to-back: a new start is accepted in the first cycle busy=0, i.e. the same cycle the result is readable.
// STRUCTURE
// - Shared header md_defs.vh holds the OP_SPECIAL and FUNCT_MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO constants.
//   The same constants are used by the D/E/W control decoders and the hazard unit.
// - One sub-module, md_decode: combinational IR_E -> {is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo}.
// - Datapath (multiply, divide, staging regs, counter, HI/LO) lives in this module.
// TESTING
// - Reset: drop rst_n during RUN after 2 cycles of a div -> busy=0 immediately, HI=LO=0, no later commit.
// - mult signed: A=0xFFFFFFFE(-2), B=3 -> busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
// - multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//   HI/LO unchanged during cycles 1..5.
// - div signed: A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
// - Divide by zero: HI=0x11, LO=0x22 preloaded, divu A=5, B=0 -> busy for 10 cycles; then HI=0x11, LO=0x22.
// - Ignored while busy: mtlo A=0xABCD issued during mult busy is ignored and start=0.
//   mtlo A=0xABCD issued when idle -> LO=0xABCD next cycle, busy stays 0.

Source files
------------

// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared opcode/funct constants for the multiply/divide path, plus the
// decode bundle and state encodings used by muldiv_hilo_unit.
package muldiv_hilo_unit_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic is_mult;
        logic is_multu;
        logic is_div;
        logic is_divu;
        logic is_mthi;
        logic is_mtlo;
    } md_dec_t;

    // True for the four ops that occupy the unit for a multi-cycle period.
    function automatic logic md_is_long(input md_dec_t dec);
        return dec.is_mult | dec.is_multu | dec.is_div | dec.is_divu;
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_md_decode.sv
// Combinational decode of the E-stage instruction into one-hot md op flags.
module md_decode
    import muldiv_hilo_unit_pkg::*;
(
    input  logic [31:0] ir_e,
    output md_dec_t     dec
);

    // Only op and funct matter; register and shamt fields are don't-care here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir_e[25:6];

    // Map op/funct to exactly one flag; everything else decodes to all-zero.
    always_comb begin
        dec = '0;
        if (ir_e[31:26] == OP_SPECIAL) begin
            case (ir_e[5:0])
                FUNCT_MULT:  dec.is_mult  = 1'b1;
                FUNCT_MULTU: dec.is_multu = 1'b1;
                FUNCT_DIV:   dec.is_div   = 1'b1;
                FUNCT_DIVU:  dec.is_divu  = 1'b1;
                FUNCT_MTHI:  dec.is_mthi  = 1'b1;
                FUNCT_MTLO:  dec.is_mtlo  = 1'b1;
                default:     dec = '0;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// E-stage multiply/divide unit and sole owner of the HI/LO registers.
// The result is computed at start and parked in staging registers; a
// down-counter holds busy for the op's fixed latency, then commits.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | busy=0; accepts md ops (start) and mthi/mtlo
// ST_RUN  | busy=1; counting down, commits staging to HI/LO at cnt==0
module muldiv_hilo_unit
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR_E,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    md_dec_t dec;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      stage_hi_q, stage_hi_d;
    logic [31:0]      stage_lo_q, stage_lo_d;
    logic             stage_dz_q, stage_dz_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_nz;
    logic               div_ovf;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic        [31:0] res_hi, res_lo;
    logic               res_dz;

    md_decode u_md_decode (
        .ir_e (IR_E),
        .dec  (dec)
    );

    assign busy  = (state_q == ST_RUN);
    assign start = md_is_long(dec) && (state_q == ST_IDLE);
    assign HI    = hi_q;
    assign LO    = lo_q;

    // Arithmetic: full-width products and quotient/remainder. A zero divisor
    // is replaced by 1 so the divider never sees X; the result is discarded.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        b_nz    = (B == 32'd0) ? 32'd1 : B;
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        quo_s   = $signed(A) / $signed(b_nz);
        rem_s   = $signed(A) % $signed(b_nz);
        quo_u   = A / b_nz;
        rem_u   = A % b_nz;

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_dz = 1'b0;
        if (dec.is_mult) begin
            {res_hi, res_lo} = prod_s;
        end else if (dec.is_multu) begin
            {res_hi, res_lo} = prod_u;
        end else if (dec.is_div) begin
            res_dz = (B == 32'd0);
            if (div_ovf) begin
                res_hi = 32'd0;
                res_lo = 32'h8000_0000;
            end else begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
        end else if (dec.is_divu) begin
            res_dz = (B == 32'd0);
            res_hi = rem_u;
            res_lo = quo_u;
        end
    end

    // Next-state: start/mt* in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stage_hi_d = stage_hi_q;
        stage_lo_d = stage_lo_q;
        stage_dz_d = stage_dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stage_hi_d = res_hi;
                    stage_lo_d = res_lo;
                    stage_dz_d = res_dz;
                    cnt_d      = (dec.is_mult || dec.is_multu) ? CNT_W'(MULT_LAT - 1)
                                                               : CNT_W'(DIV_LAT - 1);
                    state_d    = ST_RUN;
                end else if (dec.is_mthi) begin
                    hi_d = A;
                end else if (dec.is_mtlo) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // A divide by zero still burns the full period but leaves HI/LO alone.
                    if (!stage_dz_q) begin
                        hi_d = stage_hi_q;
                        lo_d = stage_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, staging and architectural registers; reset aborts any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            stage_hi_q <= 32'd0;
            stage_lo_q <= 32'd0;
            stage_dz_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            stage_hi_q <= stage_hi_d;
            stage_lo_q <= stage_lo_d;
            stage_dz_q <= stage_dz_d;
        end
    end

endmodule
